// File: rtl/forwarding_unit.sv
// Operand forwarding select for a 5-stage pipeline, with saturating
// statistics of how often each bypass path is taken.

module fwd_lane #(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] src,
   input  logic [REG_W-1:0] rd_ex,
   input  logic [REG_W-1:0] rd_wb,
   input  logic             ex_we,
   input  logic             wb_we,
   output logic [1:0]       sel
);
   // EX/MEM is checked last so it overrides MEM/WB: it holds the newer value.
   always_comb begin
      sel = 2'b00;
      if (wb_we && (rd_wb != '0) && (rd_wb == src)) sel = 2'b01;
      if (ex_we && (rd_ex != '0) && (rd_ex == src)) sel = 2'b10;
   end
endmodule

module forwarding_unit #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] Registro1,
   input  logic [REG_W-1:0] Registro2,
   input  logic [REG_W-1:0] Rd_execute,
   input  logic [REG_W-1:0] Rd_writeback,
   input  logic             ex_regwrite,
   input  logic             wb_regwrite,
   input  logic             stat_clr,
   output logic [1:0]       forwardA,
   output logic [1:0]       forwardB,
   output logic [CNT_W-1:0] fwd_ex_cnt,
   output logic [CNT_W-1:0] fwd_wb_cnt,
   output logic [3:0]       fwd_last
);
   localparam int NUM_LANES = 2;

   // Lane 1 is operand A, lane 0 is operand B.
   logic [NUM_LANES-1:0][REG_W-1:0] src;
   logic [NUM_LANES-1:0][1:0]       sel;

   assign src = {Registro1, Registro2};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      fwd_lane #(.REG_W(REG_W)) u_lane (
         .src   (src[i]),
         .rd_ex (Rd_execute),
         .rd_wb (Rd_writeback),
         .ex_we (ex_regwrite),
         .wb_we (wb_regwrite),
         .sel   (sel[i])
      );
   end

   assign forwardA = sel[1];
   assign forwardB = sel[0];

   logic [1:0]     ex_hits, wb_hits;
   logic [CNT_W:0] ex_sum, wb_sum;

   always_comb begin
      ex_hits = 2'd0;
      wb_hits = 2'd0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (sel[i] == 2'b10) ex_hits = ex_hits + 2'd1;
         if (sel[i] == 2'b01) wb_hits = wb_hits + 2'd1;
      end
      ex_sum = {1'b0, fwd_ex_cnt} + {{(CNT_W-1){1'b0}}, ex_hits};
      wb_sum = {1'b0, fwd_wb_cnt} + {{(CNT_W-1){1'b0}}, wb_hits};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_ex_cnt <= '0;
         fwd_wb_cnt <= '0;
         fwd_last   <= '0;
      end else begin
         fwd_last <= {forwardA, forwardB};
         if (stat_clr) begin
            fwd_ex_cnt <= '0;
            fwd_wb_cnt <= '0;
         end else begin
            // Carry out of the widened sum means the counter would wrap.
            fwd_ex_cnt <= ex_sum[CNT_W] ? '1 : ex_sum[CNT_W-1:0];
            fwd_wb_cnt <= wb_sum[CNT_W] ? '1 : wb_sum[CNT_W-1:0];
         end
      end
   end
endmodule

// File: tb/tb_forwarding_unit.sv
// Directed bench for forwarding_unit: select table plus counter/reset sequences.

module tb_forwarding_unit;
   localparam int REG_W = 5;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [REG_W-1:0] Registro1, Registro2, Rd_execute, Rd_writeback;
   logic             ex_regwrite, wb_regwrite, stat_clr;
   logic [1:0]       forwardA, forwardB;
   logic [CNT_W-1:0] fwd_ex_cnt, fwd_wb_cnt;
   logic [3:0]       fwd_last;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   forwarding_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Registro1    (Registro1),
      .Registro2    (Registro2),
      .Rd_execute   (Rd_execute),
      .Rd_writeback (Rd_writeback),
      .ex_regwrite  (ex_regwrite),
      .wb_regwrite  (wb_regwrite),
      .stat_clr     (stat_clr),
      .forwardA     (forwardA),
      .forwardB     (forwardB),
      .fwd_ex_cnt   (fwd_ex_cnt),
      .fwd_wb_cnt   (fwd_wb_cnt),
      .fwd_last     (fwd_last)
   );

   typedef struct {
      logic [REG_W-1:0] r1, r2, rde, rdw;
      logic             exw, wbw;
      logic [1:0]       exp_a, exp_b;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      Registro1    = v.r1;
      Registro2    = v.r2;
      Rd_execute   = v.rde;
      Rd_writeback = v.rdw;
      ex_regwrite  = v.exw;
      wb_regwrite  = v.wbw;
   endtask

   initial begin
      vec_t v;
      //            r1  r2  rde rdw exw wbw  A      B
      vecs[0] = '{ 3,  4,  1,  2,  0,  0, 2'b00, 2'b00};
      vecs[1] = '{ 3,  4,  3,  2,  1,  0, 2'b10, 2'b00};
      vecs[2] = '{ 3,  4,  3,  3,  0,  1, 2'b01, 2'b00};
      vecs[3] = '{ 3,  4,  4,  3,  1,  1, 2'b01, 2'b10};
      vecs[4] = '{ 5,  1,  5,  5,  1,  1, 2'b10, 2'b00};
      vecs[5] = '{ 0,  0,  0,  0,  1,  1, 2'b00, 2'b00};
      vecs[6] = '{ 6,  6,  1,  6,  0,  1, 2'b01, 2'b01};
      vecs[7] = '{ 7,  7,  7,  7,  0,  0, 2'b00, 2'b00};
      vecs[8] = '{ 2,  9,  9,  2,  1,  1, 2'b01, 2'b10};
      vecs[9] = '{31, 31, 31,  0,  1,  0, 2'b10, 2'b10};

      rst_n = 1'b0;
      stat_clr = 1'b0;
      drive(vecs[1]);
      #2;
      chk("reset_ex_cnt", fwd_ex_cnt, 0);
      chk("reset_wb_cnt", fwd_wb_cnt, 0);
      chk("reset_fwd_last", fwd_last, 0);
      chk("reset_comb_fwdA", forwardA, 2'b10);

      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         chk($sformatf("vec%0d_fwdA", i), forwardA, vecs[i].exp_a);
         chk($sformatf("vec%0d_fwdB", i), forwardB, vecs[i].exp_b);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_fwd_last", i), fwd_last, {vecs[i].exp_a, vecs[i].exp_b});
      end

      // Clear wins over a cycle that would increment both counters.
      @(negedge clk);
      drive(vecs[3]);
      stat_clr = 1'b1;
      @(posedge clk); #1;
      chk("clr_priority_ex", fwd_ex_cnt, 0);
      chk("clr_priority_wb", fwd_wb_cnt, 0);
      @(negedge clk);
      stat_clr = 1'b0;
      @(posedge clk); #1;
      chk("mixed_ex_cnt", fwd_ex_cnt, 1);
      chk("mixed_wb_cnt", fwd_wb_cnt, 1);

      // Both operands forward from EX/MEM: +2 per edge.
      @(negedge clk);
      v = '{7, 7, 7, 0, 1, 0, 2'b10, 2'b10};
      drive(v);
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("three_clk_ex_cnt", fwd_ex_cnt, 6);
      chk("three_clk_wb_cnt", fwd_wb_cnt, 0);
      @(negedge clk);
      stat_clr = 1'b1;
      @(posedge clk); #1;
      chk("stat_clr_ex", fwd_ex_cnt, 0);
      @(negedge clk);
      stat_clr = 1'b0;

      repeat (7) @(posedge clk);
      #1;
      chk("near_max_ex", fwd_ex_cnt, 14);
      @(posedge clk); #1;
      chk("saturate_ex", fwd_ex_cnt, 15);
      @(posedge clk); #1;
      chk("saturate_hold_ex", fwd_ex_cnt, 15);
      chk("fwd_last_before_rst", fwd_last, 4'b1010);

      // Asynchronous reset away from any clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_ex_cnt", fwd_ex_cnt, 0);
      chk("midrst_wb_cnt", fwd_wb_cnt, 0);
      chk("midrst_fwd_last", fwd_last, 0);
      chk("midrst_comb_fwdB", forwardB, 2'b10);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("first_edge_ex_cnt", fwd_ex_cnt, 2);
      chk("first_edge_fwd_last", fwd_last, 4'b1010);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
